// File: rtl/i_ref_sweep_ctrl.sv
// Reference-current sweep sequencer: ramps i_ref in fixed steps and settles after each step.
// It strobes ready for the sampler and aborts to a safe code on the first detected instability.
module i_ref_sweep_ctrl #(
  parameter int BUS_WIDTH     = 10,
  parameter int I_START       = 1,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 unstable,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 ready,
  output logic                 went_unstable,
  output logic [BUS_WIDTH-1:0] i_ref_max,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETTLE   = 3'd1;
  localparam logic [2:0] ST_SAMPLE   = 3'd2;
  localparam logic [2:0] ST_UNSTABLE = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam int CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [BUS_WIDTH:0] CODE_MAX    = {1'b0, {BUS_WIDTH{1'b1}}};
  localparam logic [BUS_WIDTH:0] STEP_EXT    = (BUS_WIDTH + 1)'(STEP);
  localparam logic [BUS_WIDTH-1:0] START_CODE = BUS_WIDTH'(I_START);

  logic [2:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BUS_WIDTH-1:0] i_ref_reg, i_ref_next;
  logic [BUS_WIDTH-1:0] i_ref_max_reg, i_ref_max_next;
  logic                 ready_reg, ready_next;
  logic                 fault_reg, fault_next;
  logic                 unstable_meta_reg, unstable_s;
  logic [BUS_WIDTH:0]   next_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unstable_meta_reg <= 1'b0;
      unstable_s        <= 1'b0;
    end else begin
      unstable_meta_reg <= unstable;
      unstable_s        <= unstable_meta_reg;
    end
  end

  // Code arithmetic is one bit wider so that saturation is visible as an overflow.
  assign next_code = {1'b0, i_ref_reg} + STEP_EXT;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    i_ref_next     = i_ref_reg;
    i_ref_max_next = i_ref_max_reg;
    ready_next     = ready_reg;
    fault_next     = fault_reg;

    if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      i_ref_next = '0;
      ready_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (state_reg == ST_IDLE) i_ref_next = '0;
          if (start) begin
            state_next     = ST_SETTLE;
            cnt_next       = '0;
            i_ref_next     = START_CODE;
            i_ref_max_next = '0;
            fault_next     = 1'b0;
          end
        end
        ST_SETTLE, ST_SAMPLE: begin
          if (unstable_s) begin
            state_next = ST_UNSTABLE;
            cnt_next   = '0;
            i_ref_next = '0;
            ready_next = 1'b0;
            // Every applied code is nonzero, so a zero max means nothing completed sampling.
            if (i_ref_max_reg == '0) fault_next = 1'b1;
          end else if (state_reg == ST_SETTLE) begin
            if (cnt_reg == SETTLE_LAST) begin
              state_next = ST_SAMPLE;
              cnt_next   = '0;
              ready_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end else begin
            if (cnt_reg == HOLD_LAST) begin
              cnt_next       = '0;
              ready_next     = 1'b0;
              i_ref_max_next = i_ref_reg;
              if (next_code > CODE_MAX) begin
                state_next = ST_DONE;
              end else begin
                state_next = ST_SETTLE;
                i_ref_next = next_code[BUS_WIDTH-1:0];
              end
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
        end
        ST_UNSTABLE: begin
          state_next = ST_DONE;
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          i_ref_next = '0;
          ready_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      i_ref_reg     <= '0;
      i_ref_max_reg <= '0;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      i_ref_reg     <= i_ref_next;
      i_ref_max_reg <= i_ref_max_next;
      ready_reg     <= ready_next;
      fault_reg     <= fault_next;
    end
  end

  assign i_ref         = i_ref_reg;
  assign i_ref_max     = i_ref_max_reg;
  assign ready         = ready_reg;
  assign fault         = fault_reg;
  assign went_unstable = (state_reg == ST_UNSTABLE);
  assign done          = (state_reg == ST_DONE);
  assign busy          = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE) ||
                         (state_reg == ST_UNSTABLE);

endmodule

// File: tb/tb_i_ref_sweep_ctrl.sv
// Bench for i_ref_sweep_ctrl: two configurations driven together and compared every cycle
// against a sweep model that derives the code and strobe from elapsed time in the sweep.
module tb_i_ref_sweep_ctrl;

  localparam int BW   = 4;
  localparam int S    = 8;
  localparam int H    = 3;
  localparam int P    = S + H;
  localparam int CMAX = 15;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_UNST = 2;
  localparam int M_DONE = 3;

  typedef struct {
    int mode;
    int t;
    int hold_code;
    int mx;
    int nfin;
    bit fault;
    bit s1;
    bit s2;
  } model_t;

  logic clk = 1'b0;
  logic rst, enable, start, unstable;
  logic [BW-1:0] i_ref_a, max_a, i_ref_b, max_b;
  logic ready_a, wu_a, busy_a, done_a, fault_a;
  logic ready_b, wu_b, busy_b, done_b, fault_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  model_t ma, mb;

  int qa_cyc[$];
  int qa_code[$];
  int qb_code[$];
  int rd_hi_a = 0;
  int wu_cnt_a = 0;
  logic ready_a_prev = 1'b0;
  logic ready_b_prev = 1'b0;

  always #5 clk = ~clk;

  i_ref_sweep_ctrl #(.BUS_WIDTH(BW), .I_START(1), .STEP(1), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .unstable(unstable),
    .i_ref(i_ref_a), .ready(ready_a), .went_unstable(wu_a), .i_ref_max(max_a),
    .busy(busy_a), .done(done_a), .fault(fault_a));

  i_ref_sweep_ctrl #(.BUS_WIDTH(BW), .I_START(3), .STEP(4), .SETTLE_CYCLES(S), .HOLD_CYCLES(H)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .unstable(unstable),
    .i_ref(i_ref_b), .ready(ready_b), .went_unstable(wu_b), .i_ref_max(max_b),
    .busy(busy_b), .done(done_b), .fault(fault_b));

  function automatic model_t model_reset();
    model_t m;
    m.mode = M_IDLE; m.t = 0; m.hold_code = 0; m.mx = 0; m.nfin = 0;
    m.fault = 1'b0; m.s1 = 1'b0; m.s2 = 1'b0;
    return m;
  endfunction

  // The code of a running sweep is a function of how many full step periods have elapsed.
  function automatic int code_at(model_t m, int i0, int stp);
    return i0 + stp * (m.t / P);
  endfunction

  function automatic model_t model_step(model_t m, bit en, bit st, bit un, int i0, int stp);
    model_t n = m;
    int code;
    n.s1 = un;
    n.s2 = m.s1;
    code = code_at(m, i0, stp);
    if (m.mode == M_IDLE || m.mode == M_DONE) begin
      if (en && st) begin
        n.mode = M_RUN; n.t = 0; n.mx = 0; n.nfin = 0; n.fault = 1'b0;
      end else if (!en) begin
        n.mode = M_IDLE;
      end
    end else if (!en) begin
      n.mode = M_IDLE;
    end else if (m.mode == M_UNST) begin
      n.mode = M_DONE; n.hold_code = 0;
    end else if (m.s2) begin
      n.mode = M_UNST;
      if (m.nfin == 0) n.fault = 1'b1;
    end else if (m.t % P == P - 1) begin
      n.mx = code;
      n.nfin = m.nfin + 1;
      if (code + stp > CMAX) begin
        n.mode = M_DONE; n.hold_code = code;
      end else begin
        n.t = m.t + 1;
      end
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  function automatic int exp_iref(model_t m, int i0, int stp);
    if (m.mode == M_RUN) return code_at(m, i0, stp);
    if (m.mode == M_DONE) return m.hold_code;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input int iref, input bit rdy, input bit wu, input int mx,
                     input bit bz, input bit dn, input bit flt, input model_t m,
                     input int i0, input int stp);
    chk({tag, "_i_ref"}, iref, exp_iref(m, i0, stp));
    chk({tag, "_ready"}, int'(rdy), int'(m.mode == M_RUN && (m.t % P) >= S));
    chk({tag, "_went_unstable"}, int'(wu), int'(m.mode == M_UNST));
    chk({tag, "_i_ref_max"}, mx, m.mx);
    chk({tag, "_busy"}, int'(bz), int'(m.mode == M_RUN || m.mode == M_UNST));
    chk({tag, "_done"}, int'(dn), int'(m.mode == M_DONE));
    chk({tag, "_fault"}, int'(flt), int'(m.fault));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, enable, start, unstable, 1, 1);
      mb <= model_step(mb, enable, start, unstable, 3, 4);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      cmp("a", int'(i_ref_a), ready_a, wu_a, int'(max_a), busy_a, done_a, fault_a, ma, 1, 1);
      cmp("b", int'(i_ref_b), ready_b, wu_b, int'(max_b), busy_b, done_b, fault_b, mb, 3, 4);
    end
    if (ready_a && !ready_a_prev) begin
      qa_cyc.push_back(cyc);
      qa_code.push_back(int'(i_ref_a));
    end
    if (ready_b && !ready_b_prev) qb_code.push_back(int'(i_ref_b));
    if (ready_a) rd_hi_a++;
    if (wu_a) wu_cnt_a++;
    ready_a_prev <= ready_a;
    ready_b_prev <= ready_b;
  end

  task automatic clear_mon();
    qa_cyc.delete();
    qa_code.delete();
    qb_code.delete();
    rd_hi_a = 0;
    wu_cnt_a = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int bound);
    int n = 0;
    while (!done_a && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, int'(done_a), 1);
  endtask

  task automatic wait_code_a(input string name, input int code, input int bound);
    int n = 0;
    while (int'(i_ref_a) != code && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, int'(i_ref_a), code);
  endtask

  initial begin
    int t0;
    int n;
    rst = 1'b0; enable = 1'b0; start = 1'b0; unstable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_i_ref", int'(i_ref_a), 0);
    chk("reset_ready", int'(ready_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_max", int'(max_a), 0);
    rst = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Full sweep without instability in both configurations.
    clear_mon();
    pulse_start();
    t0 = cyc;
    wait_done_a("sweep_done_wait", 400);
    chk("sweep_ready_count", qa_cyc.size(), 15);
    if (qa_cyc.size() > 0) chk("first_ready_latency", qa_cyc[0] - t0, S);
    for (int i = 1; i < qa_cyc.size(); i++) chk("ready_spacing", qa_cyc[i] - qa_cyc[i-1], P);
    for (int i = 0; i < qa_code.size(); i++) chk("sweep_code_a", qa_code[i], i + 1);
    chk("sweep_i_ref", int'(i_ref_a), 15);
    chk("sweep_max", int'(max_a), 15);
    chk("sweep_fault", int'(fault_a), 0);
    chk("model_sweep_max", ma.mx, 15);
    chk("b_ready_count", qb_code.size(), 4);
    for (int i = 0; i < qb_code.size(); i++) chk("b_code", qb_code[i], 3 + 4 * i);
    chk("b_i_ref", int'(i_ref_b), 15);
    chk("b_done", int'(done_b), 1);

    // Instability during the settle of code 6, restarted straight from DONE.
    clear_mon();
    pulse_start();
    wait_code_a("wait_code6", 6, 200);
    unstable = 1'b1;
    wait_done_a("unst6_done_wait", 50);
    chk("unst6_wu_pulses", wu_cnt_a, 1);
    chk("unst6_i_ref", int'(i_ref_a), 0);
    chk("unst6_max", int'(max_a), 5);
    chk("unst6_fault", int'(fault_a), 0);
    chk("unst6_ready_count", qa_cyc.size(), 5);
    unstable = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Instability reaches the synchronized path in the second ready cycle of code 1.
    clear_mon();
    pulse_start();
    repeat (7) @(posedge clk);
    #2;
    unstable = 1'b1;
    wait_done_a("unst1_done_wait", 50);
    chk("unst1_ready_cycles", rd_hi_a, 2);
    chk("unst1_max", int'(max_a), 0);
    chk("unst1_fault", int'(fault_a), 1);
    chk("unst1_wu_pulses", wu_cnt_a, 1);
    unstable = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Enable dropped mid-settle of code 9, then a fresh sweep.
    pulse_start();
    wait_code_a("wait_code9", 9, 200);
    repeat (3) @(posedge clk);
    #2;
    enable = 1'b0;
    @(posedge clk); #2;
    chk("dis_i_ref", int'(i_ref_a), 0);
    chk("dis_max", int'(max_a), 8);
    chk("dis_busy", int'(busy_a), 0);
    chk("dis_done", int'(done_a), 0);
    enable = 1'b1;
    pulse_start();
    chk("restart_i_ref", int'(i_ref_a), 1);
    chk("restart_max", int'(max_a), 0);
    chk("restart_busy", int'(busy_a), 1);

    // Asynchronous reset in the middle of a sample interval.
    n = 0;
    while (!ready_a && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("wait_ready", int'(ready_a), 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("areset_i_ref", int'(i_ref_a), 0);
    chk("areset_ready", int'(ready_a), 0);
    chk("areset_busy", int'(busy_a), 0);
    chk("areset_max", int'(max_a), 0);
    chk("areset_b_i_ref", int'(i_ref_b), 0);
    #3;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("post_reset_busy", int'(busy_a), 0);
    chk("post_reset_i_ref", int'(i_ref_a), 0);
    chk("post_reset_done", int'(done_a), 0);

    // Random segments of enable, start and instability, checked every cycle by the model.
    for (int seg = 0; seg < 80; seg++) begin
      enable   = ($urandom_range(0, 9) != 0);
      start    = ($urandom_range(0, 2) == 0);
      unstable = ($urandom_range(0, 5) == 0);
      @(posedge clk); #2;
      start = 1'b0;
      if ($urandom_range(0, 1) == 0) begin
        #($urandom_range(0, 6));
        unstable = ($urandom_range(0, 7) == 0);
      end
      repeat ($urandom_range(1, 40)) @(posedge clk);
      #2;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_ref_sweep_ctrl.md
# i_ref_sweep_ctrl

Sequencer for the reference-current sampling path. It ramps the `i_ref` code upward in fixed steps and waits a settle interval after each step. It then strobes `ready` so the downstream sampler captures the code, and watches the instability detector. On the first instability it drops the code to a safe value, pulses `went_unstable` to the sampler, and reports the last stable code it applied.

## Interface
- `BUS_WIDTH`, 10, width of the `i_ref` code and of `i_ref_max`.
- `I_START`, 1, first code applied after `start`; must be in 1..2^BUS_WIDTH-1.
- `STEP`, 1, code increment per step; must be ≥1.
- `SETTLE_CYCLES`, 8, clocks each code is held before sampling; must be ≥1.
- `HOLD_CYCLES`, 3, width of each `ready` pulse in clocks; must be ≥1.
- `clk  in  1`  single clock; all state changes on the rising edge.
- `rst  in  1`  asynchronous, active-low reset.
- `enable  in  1`  when low, the block aborts to IDLE.
- `start  in  1`  sampled in IDLE or DONE; a high level starts a sweep.
- `unstable  in  1`  asynchronous level from the instability detector; passes through an internal 2-FF synchronizer (`unstable_s`).
- `i_ref  out  BUS_WIDTH`  current reference code driven to the DAC and the sampler.
- `ready  out  1`  sample strobe to the sampler.
- `went_unstable  out  1`  one-cycle pulse to the sampler on detected instability.
- `i_ref_max  out  BUS_WIDTH`  last code that completed a full sample interval without instability.
- `busy  out  1`  high in SETTLE, SAMPLE and UNSTABLE.
- `done  out  1`  high in DONE.
- `fault  out  1`  instability occurred before any code completed sampling; valid while `done`=1.

## Operation
- Reset (rst=0, async): state=IDLE, `i_ref`=0, `ready`=0, `went_unstable`=0, `i_ref_max`=0, `busy`=0, `done`=0, `fault`=0, sync flops=0, counter=0.
- IDLE: `i_ref`=0. If `enable`&`start`, then `i_ref`←I_START, counter←0, `i_ref_max`←0, `fault`←0, and the state moves to SETTLE.
- SETTLE: counter increments each clock. When counter=SETTLE_CYCLES-1, counter←0 and the state moves to SAMPLE.
- SAMPLE: `ready`=1 (registered output, high for exactly HOLD_CYCLES clocks). On the last hold clock:
  - `i_ref_max`←`i_ref`.
  - The next code is computed in BUS_WIDTH+1 bits. If `i_ref`+STEP > 2^BUS_WIDTH-1, the ramp is saturated: the state moves to DONE and `i_ref` is held at its value.
  - Otherwise `i_ref`←`i_ref`+STEP and the state moves to SETTLE.
- UNSTABLE is entered from SETTLE or SAMPLE whenever `unstable_s`=1. This takes priority over every counter transition in the same cycle.
  - `ready`←0, `i_ref`←0, and `i_ref_max` is not updated; an aborted sample is never recorded.
  - `fault`←1 if no code has completed SAMPLE since `start`.
  - `went_unstable`=1 for exactly the one cycle the state is UNSTABLE, then the state moves to DONE.
- DONE: `done`=1 and `i_ref` is held (0 after instability; last code after saturation). `start`&`enable` restarts the sweep exactly as from IDLE. `enable`=0 moves the state to IDLE.
- `enable`=0 in any non-IDLE state moves to IDLE on the next edge. `i_ref`←0, `ready`/`went_unstable`/`busy`/`done` clear, and `i_ref_max` and `fault` are retained.
- `unstable_s` is ignored in IDLE and DONE.
- `start` held high is not an error. A new sweep begins only from IDLE or DONE.

## Timing
- From `start` sampled at edge N:
  - `busy`=1 and `i_ref`=I_START from N+1.
  - `ready` rises at N+1+SETTLE_CYCLES and stays high for HOLD_CYCLES clocks.
- Step period: SETTLE_CYCLES+HOLD_CYCLES clocks.
- `i_ref_max` and the next `i_ref` both update on the edge where `ready` falls.
- `unstable` latency: an assertion captured at edge E appears on `unstable_s` at E+1. The state is UNSTABLE, with `went_unstable`=1, `ready`=0 and `i_ref`=0, after edge E+2. `done` follows one cycle later.
- Number of codes in a full sweep: floor((2^BUS_WIDTH-1-I_START)/STEP)+1.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock.

## Test plan
- BUS_WIDTH=4, I_START=1, STEP=1, SETTLE=8, HOLD=3, `unstable` low, pulse `start` → 15 `ready` pulses (codes 1..15), each 11 clocks apart. Then `done`=1, `i_ref`=15, `i_ref_max`=15, `fault`=0.
- Same configuration, raise `unstable` during SETTLE of code 6 → `went_unstable` is a single one-cycle pulse, `i_ref`=0, `i_ref_max`=5, `done`=1, `fault`=0, and no `ready` is seen for code 6.
- `unstable` rises in the second `ready` cycle of code 1 → `ready` drops early, `i_ref_max`=0, `fault`=1.
- STEP=4, I_START=3 → codes 3,7,11,15 only; saturation stops after 15 with no wrap to 3.
- `enable`=0 mid-SETTLE of code 9 → state IDLE next edge, `i_ref`=0, `i_ref_max`=8 retained. Re-enable and `start` → sweep restarts at 1 and `i_ref_max` clears to 0.
- `rst`=0 asserted between clock edges during SAMPLE → all outputs go to reset values immediately. After release, the block stays in IDLE until `start`.
